remote_update_avalon_bridge: RTL and testbench

REMOTE_UPDATE_AVALON_BRIDGE -- requirements
Module: remote_update_avalon_bridge

---
 rtl/remote_update_avalon_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_remote_update_avalon_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_update_avalon_bridge.sv
// Avalon-MM slave bridging CPU accesses onto a remote-update core parameter port,
// plus a small local register block (status, control, reconfiguration trigger).
module remote_update_avalon_bridge #(
    parameter int unsigned DIN_W       = 22,
    parameter int unsigned DOUT_W      = 29,
    parameter int unsigned BUSY_WAIT   = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_readdatavalid,
    output logic              av_waitrequest,
    output logic              ru_read_param,
    output logic              ru_write_param,
    output logic [2:0]        ru_param,
    output logic [1:0]        ru_source,
    output logic [DIN_W-1:0]  ru_datain,
    output logic              ru_reset,
    output logic              ru_reconfig,
    input  logic              ru_busy,
    input  logic [DOUT_W-1:0] ru_dataout,
    output logic              irq
);

    localparam int unsigned      CNT_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST    = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       OFS_STATUS   = 3'd0;
    localparam logic [2:0]       OFS_CONTROL  = 3'd1;
    localparam logic [2:0]       OFS_RECONFIG = 3'd2;
    localparam logic [7:0]       RECONFIG_KEY = 8'h5A;
    localparam logic [31:0]      TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_is_read;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;
    logic              r_irq_en;
    logic [2:0]        r_param;
    logic [1:0]        r_source;
    logic [DIN_W-1:0]  r_datain;
    logic              r_read_param;
    logic              r_write_param;
    logic              r_reconfig;
    logic              r_irq;
    logic [31:0]       r_readdata;
    logic              r_readdatavalid;
    logic [1:0]        r_rst_sync;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_local;
    logic [2:0]        w_ofs;
    logic              w_waiting;
    logic              w_op_done;
    logic              w_cnt_expired;
    logic              w_to_set;
    logic              w_to_clr;
    logic [31:0]       w_local_rdata;
    logic              w_unused_wdata;

    // A simultaneous read and write is served as a read only.
    assign w_rd_acc      = (r_state == S_IDLE) && av_read;
    assign w_wr_acc      = (r_state == S_IDLE) && av_write && !av_read;
    assign w_local       = av_address[5];
    assign w_ofs         = av_address[2:0];
    assign w_waiting     = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_op_done     = ((r_state == S_WAIT_BUSY) && !ru_busy && (r_cnt == BUSY_LAST))
                        || ((r_state == S_WAIT_DONE) && !ru_busy);
    assign w_cnt_expired = (r_cnt == TO_LAST);
    assign w_to_set      = w_waiting && !w_op_done && w_cnt_expired;
    assign w_to_clr      = w_wr_acc && w_local && (w_ofs == OFS_CONTROL) && av_writedata[0];
    assign w_unused_wdata = ^av_writedata;

    always_comb begin
        w_local_rdata = '0;
        case (w_ofs)
            OFS_STATUS:  w_local_rdata = {29'd0, r_irq_en, r_timeout, ru_busy};
            OFS_CONTROL: w_local_rdata = {30'd0, r_irq_en, 1'b0};
            default:     w_local_rdata = '0;
        endcase
    end

    // Core reset held through rst_n and released two clocks after deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_is_read       <= 1'b0;
            r_cnt           <= '0;
            r_timeout       <= 1'b0;
            r_irq_en        <= 1'b0;
            r_param         <= '0;
            r_source        <= '0;
            r_datain        <= '0;
            r_read_param    <= 1'b0;
            r_write_param   <= 1'b0;
            r_reconfig      <= 1'b0;
            r_irq           <= 1'b0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_read_param    <= 1'b0;
            r_write_param   <= 1'b0;
            r_reconfig      <= 1'b0;
            r_readdatavalid <= 1'b0;
            r_irq           <= r_timeout & r_irq_en;

            // Timeout set wins over a software clear in the same cycle.
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (w_to_clr) begin
                r_timeout <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rd_acc || w_wr_acc) begin
                        if (!w_local) begin
                            r_param       <= av_address[2:0];
                            r_source      <= av_address[4:3];
                            r_datain      <= av_writedata[DIN_W-1:0];
                            r_is_read     <= w_rd_acc;
                            r_read_param  <= w_rd_acc;
                            r_write_param <= w_wr_acc;
                            r_state       <= S_ISSUE;
                        end else if (w_rd_acc) begin
                            r_readdata      <= w_local_rdata;
                            r_readdatavalid <= 1'b1;
                            r_state         <= S_RESP;
                        end else begin
                            if (w_ofs == OFS_CONTROL) begin
                                r_irq_en <= av_writedata[1];
                            end
                            if (w_ofs == OFS_RECONFIG) begin
                                r_reconfig <= (av_writedata[7:0] == RECONFIG_KEY);
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (w_op_done || w_cnt_expired) begin
                        if (r_is_read) begin
                            r_readdata      <= w_op_done ? 32'(ru_dataout) : TIMEOUT_DATA;
                            r_readdatavalid <= 1'b1;
                            r_state         <= S_RESP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if ((r_state == S_WAIT_BUSY) && ru_busy) begin
                            r_state <= S_WAIT_DONE;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign av_waitrequest   = (r_state != S_IDLE);
    assign av_readdata      = r_readdata;
    assign av_readdatavalid = r_readdatavalid;
    assign ru_read_param    = r_read_param;
    assign ru_write_param   = r_write_param;
    assign ru_param         = r_param;
    assign ru_source        = r_source;
    assign ru_datain        = r_datain;
    assign ru_reconfig      = r_reconfig;
    assign ru_reset         = r_rst_sync[1];
    assign irq              = r_irq;

endmodule

// File: tb/tb_remote_update_avalon_bridge.sv
// Bench for remote_update_avalon_bridge: directed Avalon accesses, a per-cycle
// expectation schedule derived from transaction-level rules, and literal pins.
module tb_remote_update_avalon_bridge;

    localparam int DIN_W       = 22;
    localparam int DOUT_W      = 29;
    localparam int BUSY_WAIT   = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAXC        = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0]        av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [31:0]       av_readdata;
    logic              av_readdatavalid;
    logic              av_waitrequest;
    logic              ru_read_param;
    logic              ru_write_param;
    logic [2:0]        ru_param;
    logic [1:0]        ru_source;
    logic [DIN_W-1:0]  ru_datain;
    logic              ru_reset;
    logic              ru_reconfig;
    logic              ru_busy;
    logic [DOUT_W-1:0] ru_dataout;
    logic              irq;

    remote_update_avalon_bridge #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .BUSY_WAIT(BUSY_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest),
        .ru_read_param(ru_read_param), .ru_write_param(ru_write_param),
        .ru_param(ru_param), .ru_source(ru_source), .ru_datain(ru_datain),
        .ru_reset(ru_reset), .ru_reconfig(ru_reconfig), .ru_busy(ru_busy),
        .ru_dataout(ru_dataout), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output schedule, indexed by absolute cycle.
    bit          e_wait [MAXC];
    bit          e_valid[MAXC];
    bit          e_rdp  [MAXC];
    bit          e_wrp  [MAXC];
    bit          e_rcfg [MAXC];
    bit          e_rur  [MAXC];
    bit          e_ru   [MAXC];
    bit          e_irq_has[MAXC];
    bit          e_irq_val[MAXC];
    logic [31:0] e_data [MAXC];

    bit               m_to, m_en, m_irq;
    logic [2:0]       m_prm;
    logic [1:0]       m_src;
    logic [DIN_W-1:0] m_din;

    int n_cmp = 0;
    int n_err = 0;

    int               mon_valid_cnt = 0, mon_rdp_cnt = 0, mon_wrp_cnt = 0, mon_rcfg_cnt = 0;
    int               mon_valid_cyc = 0, mon_rdp_cyc = 0, mon_run = 0, mon_last_run = 0;
    logic [31:0]      mon_data;
    logic [2:0]       mon_prm;
    logic [1:0]       mon_src;
    logic [DIN_W-1:0] mon_din;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp_v);
        end
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            if (e_irq_has[cyc]) m_irq = e_irq_val[cyc];
            chk("waitrequest",   32'(av_waitrequest),   32'(e_wait[cyc]));
            chk("readdatavalid", 32'(av_readdatavalid), 32'(e_valid[cyc]));
            chk("ru_read_param", 32'(ru_read_param),    32'(e_rdp[cyc]));
            chk("ru_write_param",32'(ru_write_param),   32'(e_wrp[cyc]));
            chk("ru_reconfig",   32'(ru_reconfig),      32'(e_rcfg[cyc]));
            chk("ru_reset",      32'(ru_reset),         32'(e_rur[cyc]));
            chk("irq",           32'(irq),              32'(m_irq));
            if (e_valid[cyc]) chk("readdata", av_readdata, e_data[cyc]);
            if (e_ru[cyc]) begin
                chk("ru_param",  32'(ru_param),  32'(m_prm));
                chk("ru_source", 32'(ru_source), 32'(m_src));
                chk("ru_datain", 32'(ru_datain), 32'(m_din));
            end
            if (!rst_n) chk("readdata_in_reset", av_readdata, 32'h0);
        end
        if (av_readdatavalid) begin
            mon_valid_cnt++; mon_data = av_readdata; mon_valid_cyc = cyc;
        end
        if (ru_read_param) begin
            mon_rdp_cnt++; mon_rdp_cyc = cyc; mon_prm = ru_param; mon_src = ru_source;
        end
        if (ru_write_param) begin
            mon_wrp_cnt++; mon_din = ru_datain;
        end
        if (ru_reconfig) mon_rcfg_cnt++;
        if (av_waitrequest) mon_run++;
        else begin
            if (mon_run > 0) mon_last_run = mon_run;
            mon_run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; av_read = 1'b0; av_write = 1'b0; ru_busy = 1'b0;
        for (int k = cyc; k < MAXC; k++) begin
            e_wait[k] = 0; e_valid[k] = 0; e_rdp[k] = 0; e_wrp[k] = 0; e_rcfg[k] = 0;
            e_rur[k] = 0; e_ru[k] = 0; e_irq_has[k] = 0; e_irq_val[k] = 0;
        end
        m_to = 0; m_en = 0; m_irq = 0;
        repeat (n) begin
            e_rur[cyc] = 1;
            step();
        end
        rst_n = 1'b1;
        e_rur[cyc] = 1;
        e_rur[cyc + 1] = 1;
        step();
        step();
    endtask

    // Remote-update access. Busy is high on offsets [r, r+len) from the ISSUE cycle.
    // The op finishes on offset d: first busy-low cycle if busy rose within the
    // watch window, else the end of the window; capped at TIMEOUT_CYC.
    task automatic ru_op(input bit rd, input bit wr, input logic [5:0] addr,
                         input logic [31:0] wd, input int r, input int len,
                         input logic [DOUT_W-1:0] dout, input int rst_t);
        int iss, d, last;
        bit to;
        iss  = cyc + 1;
        d    = (r <= BUSY_WAIT) ? r + len : BUSY_WAIT;
        to   = (d > TIMEOUT_CYC);
        if (to) d = TIMEOUT_CYC;
        last = rd ? d + 1 : d;
        m_prm = addr[2:0]; m_src = addr[4:3]; m_din = wd[DIN_W-1:0];
        for (int t = 0; t <= last; t++) begin
            e_wait[iss + t] = 1;
            e_ru[iss + t]   = 1;
        end
        if (rd) begin
            e_rdp[iss] = 1;
            e_valid[iss + d + 1] = 1;
            e_data[iss + d + 1]  = to ? 32'hDEADBEEF : 32'(dout);
        end else begin
            e_wrp[iss] = 1;
        end
        if (to && m_en) begin
            e_irq_has[iss + d + 2] = 1;
            e_irq_val[iss + d + 2] = 1;
        end
        av_address = addr; av_read = rd; av_write = wr; av_writedata = wd; ru_dataout = dout;
        step();
        av_read = 1'b0; av_write = 1'b0; ru_busy = 1'b0;
        for (int t = 1; t <= last + 1; t++) begin
            step();
            if (t == rst_t) begin
                do_reset(3);
                return;
            end
            ru_busy = (t <= d) && (t >= r) && (t < r + len);
        end
        ru_busy = 1'b0;
        if (to) m_to = 1;
    endtask

    task automatic local_rd(input logic [2:0] ofs, input bit busy);
        logic [31:0] exp_v;
        exp_v = 32'h0;
        if (ofs == 3'd0) exp_v = {29'd0, m_en, m_to, busy};
        if (ofs == 3'd1) exp_v = {30'd0, m_en, 1'b0};
        e_wait[cyc + 1]  = 1;
        e_valid[cyc + 1] = 1;
        e_data[cyc + 1]  = exp_v;
        av_address = {3'b100, ofs}; av_read = 1'b1; av_write = 1'b0; ru_busy = busy;
        step();
        av_read = 1'b0; ru_busy = 1'b0;
        step();
    endtask

    task automatic local_wr(input logic [2:0] ofs, input logic [31:0] wd);
        bit nto, nen;
        nto = m_to; nen = m_en;
        if (ofs == 3'd1) begin
            if (wd[0]) nto = 0;
            nen = wd[1];
        end
        if (ofs == 3'd2 && wd[7:0] == 8'h5A) e_rcfg[cyc + 1] = 1;
        e_irq_has[cyc + 2] = 1;
        e_irq_val[cyc + 2] = nto & nen;
        m_to = nto; m_en = nen;
        av_address = {3'b100, ofs}; av_write = 1'b1; av_read = 1'b0; av_writedata = wd;
        step();
        av_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, p0, w0, c0;
        rst_n = 1'b0; av_address = '0; av_read = 1'b0; av_write = 1'b0;
        av_writedata = '0; ru_busy = 1'b0; ru_dataout = '0;
        step();
        do_reset(3);
        local_rd(3'd0, 1'b0);

        // Read at 0x0B, busy for 5 cycles from ISSUE+1.
        v0 = mon_valid_cnt; p0 = mon_rdp_cnt;
        ru_op(1'b1, 1'b0, 6'h0B, 32'h0, 1, 5, 29'h1ABCDEF, -1);
        idle(1);
        chk("lit_read_data",    mon_data, 32'h01ABCDEF);
        chk("lit_read_valids",  32'(mon_valid_cnt - v0), 32'd1);
        chk("lit_read_strobes", 32'(mon_rdp_cnt - p0), 32'd1);
        chk("lit_read_param",   32'(mon_prm), 32'd3);
        chk("lit_read_source",  32'(mon_src), 32'd1);
        chk("lit_read_latency", 32'(mon_valid_cyc - mon_rdp_cyc), 32'd7);
        chk("lit_read_wait_len",32'(mon_last_run), 32'd8);

        // Write 0x3FFFFF to 0x04, busy never rises.
        w0 = mon_wrp_cnt;
        ru_op(1'b0, 1'b1, 6'h04, 32'h003FFFFF, 1000, 0, '0, -1);
        idle(1);
        chk("lit_write_datain",  32'(mon_din), 32'h003FFFFF);
        chk("lit_write_strobes", 32'(mon_wrp_cnt - w0), 32'd1);
        chk("lit_write_wait_len",32'(mon_last_run), 32'd3);

        // Further remote-update patterns.
        ru_op(1'b1, 1'b0, 6'h1F, 32'h0, 2, 3, 29'h1FFFFFFF, -1);
        ru_op(1'b0, 1'b1, 6'h12, 32'hFFC00001, 1, 2, '0, -1);
        ru_op(1'b0, 1'b1, 6'h19, 32'h00155555, 2, 1, '0, -1);
        w0 = mon_wrp_cnt;
        ru_op(1'b1, 1'b1, 6'h05, 32'h00012345, 1000, 0, 29'h0000ABC, -1);
        chk("lit_rw_no_write", 32'(mon_wrp_cnt - w0), 32'd0);

        // Local register space.
        local_rd(3'd0, 1'b1);
        local_wr(3'd0, 32'hFFFF_FFFF);
        local_rd(3'd5, 1'b0);
        local_wr(3'd1, 32'h2);
        local_rd(3'd1, 1'b0);
        local_rd(3'd0, 1'b0);
        local_wr(3'd1, 32'h0);

        // Read timeout with busy stuck high.
        ru_op(1'b1, 1'b0, 6'h00, 32'h0, 1, 1000, '0, -1);
        chk("lit_to_data",    mon_data, 32'hDEADBEEF);
        chk("lit_to_latency", 32'(mon_valid_cyc - mon_rdp_cyc), 32'd17);
        local_rd(3'd0, 1'b0);
        chk("lit_to_status",  mon_data, 32'h2);
        chk("lit_irq_masked", 32'(irq), 32'd0);
        local_wr(3'd1, 32'h2);
        step();
        chk("lit_irq_enabled", 32'(irq), 32'd1);
        local_wr(3'd1, 32'h1);
        step();
        chk("lit_irq_cleared", 32'(irq), 32'd0);
        local_wr(3'd1, 32'h2);
        local_rd(3'd0, 1'b0);
        chk("lit_status_en", mon_data, 32'h4);

        // Write timeout with interrupt enabled, then clear.
        ru_op(1'b0, 1'b1, 6'h08, 32'h1, 1, 1000, '0, -1);
        idle(1);
        chk("lit_wr_to_irq", 32'(irq), 32'd1);
        local_rd(3'd0, 1'b0);
        local_wr(3'd1, 32'h3);
        idle(2);

        // Reconfiguration key.
        c0 = mon_rcfg_cnt;
        local_wr(3'd2, 32'h5A);
        local_wr(3'd2, 32'h5B);
        idle(2);
        chk("lit_reconfig_pulses", 32'(mon_rcfg_cnt - c0), 32'd1);

        // Reset during WAIT_DONE of a read.
        v0 = mon_valid_cnt;
        ru_op(1'b1, 1'b0, 6'h0B, 32'h0, 1, 20, 29'h123, 4);
        idle(4);
        chk("lit_rst_no_valid", 32'(mon_valid_cnt - v0), 32'd0);
        chk("lit_rst_idle",     32'(av_waitrequest), 32'd0);
        local_rd(3'd0, 1'b0);
        local_rd(3'd1, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
